// File: rtl/stack_ptr_unit.sv
// Stack pointer with range-checked push/pop/adjust/load and a sticky fault state.
// sp/high_water/flags update 1 cycle after the request; no backpressure (ops in FAULT are dropped).
module stack_ptr_unit #(
    parameter int                 WIDTH       = 32,
    parameter logic [WIDTH-1:0]   STACK_BASE  = 32'h10010100,
    parameter logic [WIDTH-1:0]   STACK_LIMIT = 32'h10000000,
    parameter int                 STEP        = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             adj_en,
    input  logic [WIDTH-1:0] adj_val,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_data,
    input  logic             clear_err,
    output logic [WIDTH-1:0] sp,
    output logic [WIDTH-1:0] high_water,
    output logic             overflow,
    output logic             underflow,
    output logic             fault
);

    localparam int EXT_W = WIDTH + 2;

    localparam logic signed [EXT_W-1:0] LIMIT_EXT = {2'b00, STACK_LIMIT};
    localparam logic signed [EXT_W-1:0] BASE_EXT  = {2'b00, STACK_BASE};
    localparam logic signed [EXT_W-1:0] STEP_EXT  = EXT_W'(STEP);

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_FAULT  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sp_q, sp_d;
    logic [WIDTH-1:0]   hw_q, hw_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;

    logic signed [EXT_W-1:0] sp_ext;
    logic signed [EXT_W-1:0] adj_ext;
    logic signed [EXT_W-1:0] cand;
    logic                    op_vld;

    // Two guard bits: sp is an unsigned pointer, adj_val is signed, so any
    // wrap past 0 or 2**WIDTH shows up as an out-of-range candidate.
    assign sp_ext  = {2'b00, sp_q};
    assign adj_ext = {{2{adj_val[WIDTH-1]}}, adj_val};

    // push together with pop is a deliberate no-op and is never range-checked.
    assign op_vld = load_en | adj_en | (push ^ pop);

    always_comb begin
        cand = sp_ext;
        if (load_en) begin
            cand = {2'b00, load_data};
        end else if (adj_en) begin
            cand = sp_ext + adj_ext;
        end else if (push && !pop) begin
            cand = sp_ext - STEP_EXT;
        end else if (pop && !push) begin
            cand = sp_ext + STEP_EXT;
        end
    end

    always_comb begin
        state_d = state_q;
        sp_d    = sp_q;
        hw_d    = hw_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;

        if (clear_err) begin
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
            hw_d    = sp_q;
            state_d = ST_NORMAL;
        end else if (state_q == ST_NORMAL && op_vld) begin
            if (cand < LIMIT_EXT) begin
                ovf_d   = 1'b1;
                state_d = ST_FAULT;
            end else if (cand > BASE_EXT) begin
                unf_d   = 1'b1;
                state_d = ST_FAULT;
            end else begin
                sp_d = cand[WIDTH-1:0];
                if (sp_d < hw_q) begin
                    hw_d = sp_d;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_NORMAL;
            sp_q    <= STACK_BASE;
            hw_q    <= STACK_BASE;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            hw_q    <= hw_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign sp         = sp_q;
    assign high_water = hw_q;
    assign overflow   = ovf_q;
    assign underflow  = unf_q;
    assign fault      = (state_q == ST_FAULT);

endmodule

// File: tb/tb_stack_ptr_unit.sv
// Directed bench for stack_ptr_unit at default parameters; expected values are hand-computed.
module tb_stack_ptr_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        push = 1'b0;
    logic        pop = 1'b0;
    logic        adj_en = 1'b0;
    logic [31:0] adj_val = '0;
    logic        load_en = 1'b0;
    logic [31:0] load_data = '0;
    logic        clear_err = 1'b0;
    logic [31:0] sp;
    logic [31:0] high_water;
    logic        overflow;
    logic        underflow;
    logic        fault;

    int n_tests = 0;
    int n_fail  = 0;

    stack_ptr_unit dut (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .adj_en    (adj_en),
        .adj_val   (adj_val),
        .load_en   (load_en),
        .load_data (load_data),
        .clear_err (clear_err),
        .sp        (sp),
        .high_water(high_water),
        .overflow  (overflow),
        .underflow (underflow),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        push = 1'b0; pop = 1'b0; adj_en = 1'b0; load_en = 1'b0; clear_err = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic chk_state(input string tag, input logic [31:0] e_sp, input logic [31:0] e_hw,
                             input logic e_ovf, input logic e_unf, input logic e_flt);
        chk({tag, ".sp"},  sp, e_sp);
        chk({tag, ".hw"},  high_water, e_hw);
        chk({tag, ".ovf"}, {31'd0, overflow}, {31'd0, e_ovf});
        chk({tag, ".unf"}, {31'd0, underflow}, {31'd0, e_unf});
        chk({tag, ".flt"}, {31'd0, fault}, {31'd0, e_flt});
    endtask

    task automatic op_push();  push = 1'b1; step(); idle_inputs(); endtask
    task automatic op_pop();   pop = 1'b1;  step(); idle_inputs(); endtask
    task automatic op_clear(); clear_err = 1'b1; step(); idle_inputs(); endtask
    task automatic op_load(input logic [31:0] v);
        load_en = 1'b1; load_data = v; step(); idle_inputs();
    endtask
    task automatic op_adj(input logic [31:0] v);
        adj_en = 1'b1; adj_val = v; step(); idle_inputs();
    endtask

    initial begin
        #12;
        chk_state("reset", 32'h10010100, 32'h10010100, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Three pushes from empty
        op_push(); op_push(); op_push();
        chk_state("push3", 32'h100100F4, 32'h100100F4, 1'b0, 1'b0, 1'b0);

        // Pop at base underflows; ops ignored in FAULT; clear recovers
        do_reset();
        op_pop();
        chk_state("pop_base", 32'h10010100, 32'h10010100, 1'b0, 1'b1, 1'b1);
        op_push();
        chk_state("push_in_fault", 32'h10010100, 32'h10010100, 1'b0, 1'b1, 1'b1);
        op_clear();
        chk_state("clear", 32'h10010100, 32'h10010100, 1'b0, 1'b0, 1'b0);
        op_push();
        chk_state("push_after_clear", 32'h100100FC, 32'h100100FC, 1'b0, 1'b0, 1'b0);

        // Limit boundary
        op_load(32'h10000000);
        chk_state("load_limit", 32'h10000000, 32'h10000000, 1'b0, 1'b0, 1'b0);
        op_push();
        chk_state("push_limit", 32'h10000000, 32'h10000000, 1'b1, 1'b0, 1'b1);
        op_clear();
        op_load(32'h10000004);
        op_push();
        chk_state("push_to_limit", 32'h10000000, 32'h10000000, 1'b0, 1'b0, 1'b0);

        // Load above base underflows, sp holds
        op_load(32'h20000000);
        chk_state("load_above", 32'h10000000, 32'h10000000, 1'b0, 1'b1, 1'b1);

        // Signed adjust, then a huge negative adjust must not wrap
        do_reset();
        op_adj(32'hFFFFFF00);
        chk_state("adj_m256", 32'h10010000, 32'h10010000, 1'b0, 1'b0, 1'b0);
        op_adj(32'h80000000);
        chk_state("adj_min", 32'h10010000, 32'h10010000, 1'b1, 1'b0, 1'b1);
        op_clear();

        // Unaligned adjust accepted as-is
        op_adj(32'h00000003);
        chk("adj_unaligned.sp", sp, 32'h10010003);

        // Simultaneous push+pop is a no-op
        push = 1'b1; pop = 1'b1; step(); idle_inputs();
        chk_state("push_pop", 32'h10010003, 32'h10010000, 1'b0, 1'b0, 1'b0);

        // Load beats push; high_water follows the new minimum
        load_en = 1'b1; load_data = 32'h10000800; push = 1'b1; step(); idle_inputs();
        chk_state("load_wins", 32'h10000800, 32'h10000800, 1'b0, 1'b0, 1'b0);
        op_pop();
        chk_state("hw_keeps_min", 32'h10000804, 32'h10000800, 1'b0, 1'b0, 1'b0);

        // clear_err beats a same-cycle push and resets high_water to sp
        clear_err = 1'b1; push = 1'b1; step(); idle_inputs();
        chk_state("clear_ignores_op", 32'h10000804, 32'h10000804, 1'b0, 1'b0, 0);

        // Asynchronous reset pulse between edges while in FAULT
        op_load(32'h10000000);
        op_push();
        chk("pre_async.flt", {31'd0, fault}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk_state("async_rst", 32'h10010100, 32'h10010100, 1'b0, 1'b0, 1'b0);
        #1 reset = 1'b0;
        step();
        chk_state("post_rst_idle", 32'h10010100, 32'h10010100, 1'b0, 1'b0, 1'b0);
        op_push();
        chk("post_rst_push.sp", sp, 32'h100100FC);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete, expected finish before 20000");
        $fatal(1);
    end

endmodule

// File: doc/stack_ptr_unit.md
STACK_PTR_UNIT -- requirements
Module: stack_ptr_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning pointer and data width in bits.
REQ-002 The block SHALL have parameter STACK_BASE, default 32'h10010100, meaning the empty-stack pointer value and the highest legal pointer.
REQ-003 The block SHALL have parameter STACK_LIMIT, default 32'h10000000, meaning the lowest legal pointer.
REQ-004 The block SHALL have parameter STEP, default 4, meaning bytes per push/pop; it is a power of two, and STACK_BASE and STACK_LIMIT are STEP-aligned.
REQ-005 The block SHALL have the port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have the port reset, input, 1 bit; reset is asynchronous and active-high.
REQ-007 The block SHALL have the following ports, one per line (name, direction, width, meaning):
- push, in, 1, decrement pointer by STEP
- pop, in, 1, increment pointer by STEP
- adj_en, in, 1, add adj_val to pointer
- adj_val, in, WIDTH, signed two's-complement offset
- load_en, in, 1, replace pointer with load_data
- load_data, in, WIDTH, new pointer value
- clear_err, in, 1, clear fault and error flags
- sp, out, WIDTH, current pointer (registered)
- high_water, out, WIDTH, lowest pointer value reached since reset/clear
- overflow, out, 1, sticky: an operation would go below STACK_LIMIT
- underflow, out, 1, sticky: an operation would go above STACK_BASE
- fault, out, 1, high while in FAULT state

Function
REQ-008 The block SHALL implement a two-state FSM: NORMAL and FAULT.
REQ-009 In NORMAL, one operation SHALL be selected per cycle, priority load_en > adj_en > push/pop.
REQ-010 The candidate pointer SHALL be: load -> load_data; adj -> sp + adj_val; push only -> sp - STEP; pop only -> sp + STEP; push and pop together -> sp (no change, no flag).
REQ-011 The candidate SHALL be computed in WIDTH+2 signed bits so wrap-around is detected and never silently accepted.
REQ-012 If the candidate < STACK_LIMIT, sp SHALL hold, overflow SHALL set, and the FSM SHALL enter FAULT on the next edge.
REQ-013 If the candidate > STACK_BASE, sp SHALL hold, underflow SHALL set, and the FSM SHALL enter FAULT on the next edge.
REQ-014 Otherwise sp SHALL take the candidate on the next edge (latency 1 cycle), with no flag change.
REQ-015 An unaligned load_data or adj result SHALL be accepted as-is; alignment is not checked.
REQ-016 high_water SHALL update on the same edge as sp to the new sp whenever the new sp < high_water.
REQ-017 In FAULT, sp and high_water SHALL hold and push/pop/adj_en/load_en SHALL be ignored.
REQ-018 clear_err in either state SHALL clear overflow and underflow, set high_water to the current sp, and force NORMAL on the next edge; any operation requested that same cycle SHALL be ignored.
REQ-019 fault SHALL equal (state == FAULT), registered, asserting the cycle after the offending request.
REQ-020 Boundary: push at sp = STACK_LIMIT SHALL overflow; pop at sp = STACK_BASE SHALL underflow; push to exactly STACK_LIMIT SHALL be legal.

Reset
REQ-021 While reset = 1, regardless of clk, the block SHALL set sp = STACK_BASE, high_water = STACK_BASE, overflow = 0, underflow = 0, and state = NORMAL (fault = 0).
REQ-022 Reset asserted mid-operation or in FAULT SHALL override all inputs; the first update SHALL occur on the first rising clk edge after reset deasserts.

Verification
REQ-023 Reset, then push x3 (defaults) -> sp = 0x100100F4, high_water = 0x100100F4, no flags.
REQ-024 From reset, pop -> underflow = 1, sp = 0x10010100 held, fault = 1 next cycle; then push -> ignored; then clear_err -> flags 0, NORMAL.
REQ-025 load 0x10000000, then push -> overflow = 1, sp = 0x10000000 held; load 0x10000004, then push -> sp = 0x10000000, no flag.
REQ-026 sp = 0x10010100, adj_val = 0xFFFFFF00 (-256) -> sp = 0x10010000; then adj_val = 0x80000000 -> overflow, no wrap.
REQ-027 Simultaneous push and pop -> sp unchanged; load_en with push -> load wins; reset pulsed between clk edges during FAULT -> sp = 0x10010100, fault = 0 immediately.
